// File: rtl/ariane_pkg.sv
// Shared types and constants for the fetch front-end.
package ariane_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } fetch_seq_state_e;

   localparam int unsigned FETCH_WIDTH_DFLT = 32;
   localparam int unsigned FETCH_ALIGN_BITS = $clog2(FETCH_WIDTH_DFLT / 8);

   // Number of PC bits below the fetch-block boundary.
   function automatic int unsigned fetch_align_bits(input int unsigned fetch_width);
      return $clog2(fetch_width / 8);
   endfunction

endpackage

// File: rtl/fetch_addr_fifo.sv
// Small FIFO holding the addresses of issued but unanswered I-cache requests.
module fetch_addr_fifo
   import ariane_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNTW = $clog2(DEPTH + 1);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] entries [DEPTH];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
         cnt_d = cnt_q + CNTW'(push_i) - CNTW'(pop_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_q, entry_d;

      always_comb begin
         entry_d = entry_q;
         if (push_i && !flush_i && (wr_ptr_q == PW'(gi))) entry_d = data_i;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) entry_q <= '0;
         else         entry_q <= entry_d;
      end

      assign entries[gi] = entry_q;
   end

   assign data_o  = entries[rd_ptr_q];
   assign full_o  = (cnt_q == CNTW'(DEPTH));
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: sequential I-cache requests, credit/outstanding limiting,
// redirect with drop counting, and zero-latency forwarding to the re-aligner.
module fetch_sequencer
   import ariane_pkg::*;
#(
   parameter int unsigned VLEN           = 32,
   parameter int unsigned FETCH_WIDTH    = FETCH_WIDTH_DFLT,
   parameter int unsigned NR_OUTSTANDING = 2,
   parameter int unsigned IQ_DEPTH       = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [VLEN-1:0]        boot_addr_i,
   input  logic                   redirect_i,
   input  logic [VLEN-1:0]        redirect_addr_i,
   input  logic                   halt_i,
   output logic                   icache_req_o,
   output logic [VLEN-1:0]        icache_addr_o,
   input  logic                   icache_gnt_i,
   input  logic                   icache_rsp_i,
   input  logic [FETCH_WIDTH-1:0] icache_data_i,
   input  logic                   iq_credit_i,
   output logic                   realign_valid_o,
   output logic [VLEN-1:0]        realign_addr_o,
   output logic [FETCH_WIDTH-1:0] realign_data_o,
   output logic                   realign_flush_o,
   output logic                   busy_o
);

   localparam int unsigned ALIGN = fetch_align_bits(FETCH_WIDTH);
   localparam int unsigned OW    = $clog2(NR_OUTSTANDING + 1);
   localparam int unsigned CW    = $clog2(IQ_DEPTH + 1);

   fetch_seq_state_e state_q, state_d;
   logic [VLEN-1:0]  pc_q, pc_d;
   logic [OW-1:0]    outstanding_q, outstanding_d;
   logic [OW-1:0]    drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]    credits_q, credits_d;

   logic [VLEN-1:0]  pc_next_blk, redir_pc, fifo_head;
   logic [OW-1:0]    n_keep;
   logic             req, issue, fwd, drop, flush;
   logic             fifo_full, fifo_empty;
   int               credit_sum;

   assign pc_next_blk = {pc_q[VLEN-1:ALIGN] + (VLEN-ALIGN)'(1), {ALIGN{1'b0}}};
   assign redir_pc    = redirect_addr_i & ~(VLEN'(1));
   // A response landing in the redirect cycle is itself dropped, so it is not kept.
   assign n_keep      = outstanding_q - OW'(icache_rsp_i);

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      credits_d     = credits_q;
      req           = 1'b0;
      issue         = 1'b0;
      fwd           = 1'b0;
      drop          = 1'b0;
      flush         = 1'b0;
      credit_sum    = int'(credits_q);
      unique case (state_q)
         IDLE: begin
            pc_d    = redirect_i ? redir_pc : boot_addr_i;
            state_d = FETCH;
         end
         FETCH, DRAIN: begin
            if (redirect_i) begin
               flush         = 1'b1;
               drop          = icache_rsp_i;
               pc_d          = redir_pc;
               outstanding_d = n_keep;
               drop_cnt_d    = n_keep;
               credits_d     = CW'(IQ_DEPTH) - CW'(n_keep);
               credit_sum    = int'(IQ_DEPTH) - int'(n_keep);
               state_d       = (n_keep != '0) ? DRAIN : FETCH;
            end else if (state_q == FETCH) begin
               req   = !halt_i && (credits_q != '0) &&
                       (outstanding_q < OW'(NR_OUTSTANDING));
               issue = req && icache_gnt_i;
               fwd   = icache_rsp_i;
               if (issue) pc_d = pc_next_blk;
               outstanding_d = outstanding_q + OW'(issue) - OW'(icache_rsp_i);
               credits_d     = credits_q + CW'(iq_credit_i) - CW'(issue);
               credit_sum    = int'(credits_q) + int'(iq_credit_i) - int'(issue);
            end else begin
               drop          = icache_rsp_i;
               outstanding_d = outstanding_q - OW'(icache_rsp_i);
               drop_cnt_d    = drop_cnt_q - OW'(icache_rsp_i);
               credits_d     = credits_q + CW'(iq_credit_i) + CW'(icache_rsp_i);
               credit_sum    = int'(credits_q) + int'(iq_credit_i) + int'(icache_rsp_i);
               if (icache_rsp_i && (drop_cnt_q == OW'(1))) state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         pc_q          <= '0;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         credits_q     <= CW'(IQ_DEPTH);
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         credits_q     <= credits_d;
      end
   end

   fetch_addr_fifo #(
      .DEPTH (NR_OUTSTANDING),
      .WIDTH (VLEN)
   ) i_addr_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (1'b0),
      .push_i  (issue),
      .data_i  (pc_q),
      .pop_i   (fwd || drop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign icache_req_o    = req;
   assign icache_addr_o   = pc_q;
   assign realign_valid_o = fwd;
   assign realign_addr_o  = fwd ? fifo_head : '0;
   assign realign_data_o  = fwd ? icache_data_i : '0;
   assign realign_flush_o = flush;
   assign busy_o          = (outstanding_q != '0);

   a_rsp_with_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
      icache_rsp_i |-> (outstanding_q != '0));
   a_credit_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (credit_sum >= 0) && (credit_sum <= int'(IQ_DEPTH)));
   a_fifo_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      fifo_full == (outstanding_q == OW'(NR_OUTSTANDING)));
   a_fifo_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      fifo_empty == (outstanding_q == '0));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: issue, credits, redirect/drain, halt, reset, wrap.
module tb_fetch_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [31:0] boot_addr_i = 32'h8000_0000;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_addr_i = '0;
   logic        halt_i = 1'b0;
   logic        icache_req_o;
   logic [31:0] icache_addr_o;
   logic        icache_gnt_i = 1'b0;
   logic        icache_rsp_i = 1'b0;
   logic [31:0] icache_data_i = '0;
   logic        iq_credit_i = 1'b0;
   logic        realign_valid_o;
   logic [31:0] realign_addr_o;
   logic [31:0] realign_data_o;
   logic        realign_flush_o;
   logic        busy_o;

   int errors = 0;
   int checks = 0;

   fetch_sequencer #(
      .VLEN           (32),
      .FETCH_WIDTH    (32),
      .NR_OUTSTANDING (2),
      .IQ_DEPTH       (4)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .boot_addr_i     (boot_addr_i),
      .redirect_i      (redirect_i),
      .redirect_addr_i (redirect_addr_i),
      .halt_i          (halt_i),
      .icache_req_o    (icache_req_o),
      .icache_addr_o   (icache_addr_o),
      .icache_gnt_i    (icache_gnt_i),
      .icache_rsp_i    (icache_rsp_i),
      .icache_data_i   (icache_data_i),
      .iq_credit_i     (iq_credit_i),
      .realign_valid_o (realign_valid_o),
      .realign_addr_o  (realign_addr_o),
      .realign_data_o  (realign_data_o),
      .realign_flush_o (realign_flush_o),
      .busy_o          (busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (rst_ni && icache_req_o && icache_gnt_i)
         $display("%0t req  addr=%h", $time, icache_addr_o);
      if (rst_ni && realign_valid_o)
         $display("%0t fwd  addr=%h data=%h", $time, realign_addr_o, realign_data_o);
      if (rst_ni && realign_flush_o)
         $display("%0t flush", $time);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drv(input logic gnt, input logic rsp, input logic [31:0] data, input logic cred);
      icache_gnt_i  = gnt;
      icache_rsp_i  = rsp;
      icache_data_i = data;
      iq_credit_i   = cred;
      #1;
   endtask

   task automatic chk_req(input string tag, input logic exp_req, input logic [31:0] exp_addr);
      chk({tag, "_req"}, icache_req_o, exp_req);
      chk({tag, "_addr"}, icache_addr_o, exp_addr);
   endtask

   task automatic chk_fwd(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_data);
      chk({tag, "_valid"}, realign_valid_o, 1'b1);
      chk({tag, "_raddr"}, realign_addr_o, exp_addr);
      chk({tag, "_rdata"}, realign_data_o, exp_data);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      icache_data_i = 32'hDEAD_BEEF;
      #1;
      chk("rst_req", icache_req_o, 1'b0);
      chk("rst_addr", icache_addr_o, 32'h0);
      chk("rst_valid", realign_valid_o, 1'b0);
      chk("rst_rdata", realign_data_o, 32'h0);
      chk("rst_flush", realign_flush_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      rst_ni = 1'b1;
      #1;
      chk("idle_req", icache_req_o, 1'b0);

      // 1: sequential fetch, response one cycle after grant
      cyc(); drv(1, 0, 32'h0, 0);
      chk_req("t1_a", 1'b1, 32'h8000_0000);
      cyc(); drv(1, 1, 32'h1111_0000, 0);
      chk_req("t1_b", 1'b1, 32'h8000_0004);
      chk_fwd("t1_b", 32'h8000_0000, 32'h1111_0000);
      cyc(); drv(1, 1, 32'h1111_0001, 0);
      chk_req("t1_c", 1'b1, 32'h8000_0008);
      chk_fwd("t1_c", 32'h8000_0004, 32'h1111_0001);
      cyc(); drv(0, 1, 32'h1111_0002, 1);
      chk_fwd("t1_d", 32'h8000_0008, 32'h1111_0002);
      cyc(); drv(0, 0, 32'h0, 1);
      chk("t1_busy_idle", busy_o, 1'b0);
      cyc(); drv(0, 0, 32'h0, 1);

      // 2: four credits, no returns -> four requests, then one more per credit
      cyc(); drv(1, 0, 32'h0, 0);
      chk_req("t2_g", 1'b1, 32'h8000_000C);
      cyc(); drv(1, 1, 32'h2222_0000, 0);
      chk_req("t2_h", 1'b1, 32'h8000_0010);
      chk_fwd("t2_h", 32'h8000_000C, 32'h2222_0000);
      cyc(); drv(1, 1, 32'h2222_0001, 0);
      chk_req("t2_i", 1'b1, 32'h8000_0014);
      cyc(); drv(1, 1, 32'h2222_0002, 0);
      chk_req("t2_j", 1'b1, 32'h8000_0018);
      cyc(); drv(1, 1, 32'h2222_0003, 0);
      chk_fwd("t2_k", 32'h8000_0018, 32'h2222_0003);
      chk("t2_k_nocred_req", icache_req_o, 1'b0);
      cyc(); drv(1, 0, 32'h0, 0);
      chk("t2_l_nocred_req", icache_req_o, 1'b0);
      cyc(); drv(1, 0, 32'h0, 1);
      chk("t2_m_credit_cycle_req", icache_req_o, 1'b0);
      cyc(); drv(1, 0, 32'h0, 0);
      chk_req("t2_n", 1'b1, 32'h8000_001C);
      cyc(); drv(1, 1, 32'h2222_0004, 0);
      chk_fwd("t2_o", 32'h8000_001C, 32'h2222_0004);
      chk("t2_o_one_more_req", icache_req_o, 1'b0);
      repeat (4) begin
         cyc(); drv(0, 0, 32'h0, 1);
      end

      // 3: redirect with two outstanding -> drain both, restart unaligned
      cyc(); drv(1, 0, 32'h0, 0);
      chk_req("t3_t", 1'b1, 32'h8000_0020);
      cyc(); drv(1, 0, 32'h0, 0);
      chk_req("t3_u", 1'b1, 32'h8000_0024);
      cyc(); redirect_i = 1'b1; redirect_addr_i = 32'h8000_0103; drv(0, 0, 32'h0, 0);
      chk("t3_flush", realign_flush_o, 1'b1);
      chk("t3_redir_req", icache_req_o, 1'b0);
      chk("t3_busy", busy_o, 1'b1);
      cyc(); redirect_i = 1'b0; drv(1, 1, 32'h3333_0000, 0);
      chk("t3_drop1_valid", realign_valid_o, 1'b0);
      chk("t3_drop1_req", icache_req_o, 1'b0);
      chk("t3_drop1_flush", realign_flush_o, 1'b0);
      cyc(); drv(1, 1, 32'h3333_0001, 0);
      chk("t3_drop2_valid", realign_valid_o, 1'b0);
      chk("t3_drop2_req", icache_req_o, 1'b0);
      cyc(); drv(1, 0, 32'h0, 0);
      chk_req("t3_y", 1'b1, 32'h8000_0102);
      cyc(); drv(1, 0, 32'h0, 0);
      chk_req("t3_z", 1'b1, 32'h8000_0104);

      // 4: redirect coinciding with the last response -> dropped, straight to FETCH
      cyc(); drv(0, 1, 32'h4444_0000, 0);
      chk_fwd("t4_aa", 32'h8000_0102, 32'h4444_0000);
      cyc(); redirect_i = 1'b1; redirect_addr_i = 32'h8000_0200; drv(0, 1, 32'h4444_0001, 0);
      chk("t4_drop_valid", realign_valid_o, 1'b0);
      chk("t4_flush", realign_flush_o, 1'b1);
      cyc(); redirect_i = 1'b0; drv(1, 0, 32'h0, 0);
      chk_req("t4_ac", 1'b1, 32'h8000_0200);
      chk("t4_busy", busy_o, 1'b0);
      cyc(); drv(1, 0, 32'h0, 0);
      chk_req("t4_ad", 1'b1, 32'h8000_0204);

      // 5: halt for 10 cycles with two outstanding
      cyc(); halt_i = 1'b1; drv(1, 1, 32'h5555_0000, 0);
      chk("t5_h0_req", icache_req_o, 1'b0);
      chk_fwd("t5_h0", 32'h8000_0200, 32'h5555_0000);
      cyc(); drv(1, 1, 32'h5555_0001, 0);
      chk("t5_h1_req", icache_req_o, 1'b0);
      chk_fwd("t5_h1", 32'h8000_0204, 32'h5555_0001);
      for (int i = 0; i < 8; i++) begin
         cyc(); drv(1, 0, 32'h0, 0);
         chk("t5_halt_req", icache_req_o, 1'b0);
      end
      cyc(); halt_i = 1'b0; drv(1, 0, 32'h0, 0);
      chk_req("t5_resume", 1'b1, 32'h8000_0208);
      cyc(); drv(1, 1, 32'h5555_0002, 0);
      chk_req("t5_r1", 1'b1, 32'h8000_020C);
      chk_fwd("t5_r1", 32'h8000_0208, 32'h5555_0002);
      cyc(); drv(1, 1, 32'h5555_0003, 0);
      chk_fwd("t5_r2", 32'h8000_020C, 32'h5555_0003);
      chk("t5_cred_exhaust_req", icache_req_o, 1'b0);

      // 6: reset in the middle of DRAIN
      cyc(); drv(0, 0, 32'h0, 1);
      cyc(); drv(0, 0, 32'h0, 1);
      cyc(); drv(1, 0, 32'h0, 0);
      chk_req("t6_a", 1'b1, 32'h8000_0210);
      cyc(); drv(1, 0, 32'h0, 0);
      chk_req("t6_b", 1'b1, 32'h8000_0214);
      cyc(); redirect_i = 1'b1; redirect_addr_i = 32'h8000_0300; drv(0, 0, 32'h0, 0);
      chk("t6_flush", realign_flush_o, 1'b1);
      cyc(); redirect_i = 1'b0; drv(0, 0, 32'h0, 0);
      chk("t6_drain_busy", busy_o, 1'b1);
      chk("t6_drain_req", icache_req_o, 1'b0);
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_req", icache_req_o, 1'b0);
      chk("t6_rst_addr", icache_addr_o, 32'h0);
      chk("t6_rst_busy", busy_o, 1'b0);
      chk("t6_rst_flush", realign_flush_o, 1'b0);
      chk("t6_rst_valid", realign_valid_o, 1'b0);
      cyc(); cyc();
      rst_ni = 1'b1;
      #1;
      chk("t6_idle_req", icache_req_o, 1'b0);
      cyc(); drv(1, 0, 32'h0, 0);
      chk_req("t6_boot", 1'b1, 32'h8000_0000);
      cyc(); drv(0, 1, 32'h6666_0000, 0);
      chk_fwd("t6_boot", 32'h8000_0000, 32'h6666_0000);

      // Address wrap at 2^VLEN
      cyc(); redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFF; drv(0, 0, 32'h0, 0);
      chk("wrap_flush", realign_flush_o, 1'b1);
      cyc(); redirect_i = 1'b0; drv(1, 0, 32'h0, 0);
      chk_req("wrap_a", 1'b1, 32'hFFFF_FFFE);
      cyc(); drv(1, 1, 32'h7777_0000, 0);
      chk_req("wrap_b", 1'b1, 32'h0000_0000);
      chk_fwd("wrap_b", 32'hFFFF_FFFE, 32'h7777_0000);
      cyc(); drv(0, 1, 32'h7777_0001, 0);
      chk_fwd("wrap_c", 32'h0000_0000, 32'h7777_0001);
      cyc(); drv(0, 0, 32'h0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
